// File: rtl/instr_queue_fetch.sv
// Instruction queue between the loader write strobe and the 19-bit CPU decode stage.
// Words are buffered in order and issued one per handshake, with flush and enable gating.
module instr_queue_fetch #(
  parameter int IW    = 19,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we_IM,
  input  logic [IW-1:0] codein,
  input  logic          flush,
  output logic [IW-1:0] instr_out,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [1:0]    op_cls,
  output logic [2:0]    op_code,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic [CW-1:0] issued
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_next;
  logic          push;
  logic          pop;
  logic          valid_q;

  assign instr_valid = valid_q;
  assign instr_out   = mem[rd_ptr];
  assign op_cls      = instr_out[IW-1:IW-2];
  assign op_code     = instr_out[IW-3:IW-5];

  // A flush discards any handshake or write landing in the same cycle.
  assign pop  = valid_q && instr_ready && !flush;
  assign push = we_IM && (!full || pop) && !flush;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = flush ? FLUSH : (en ? RUN : IDLE);
      RUN:     state_next = flush ? FLUSH : (en ? RUN : IDLE);
      FLUSH:   state_next = en ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + (AW+1)'(1);
    end else if (pop && !push) begin
      count_next = count - (AW+1)'(1);
    end
  end

  // instr_valid is registered from next-state values so a word written into an
  // empty queue is visible with no extra bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      issued   <= '0;
    end else begin
      state   <= state_next;
      valid_q <= (state_next == RUN) && (count_next != '0);
      count   <= count_next;
      full    <= (count_next == (AW+1)'(DEPTH));
      empty   <= (count_next == '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (pop) issued <= issued + CW'(1);
      if (we_IM && full && !pop && !flush) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= codein;
  end

endmodule
